// File: rtl/mmio_timer_slave.sv
// Memory-mapped down-counting timer with prescaler, one-shot or auto-reload
// modes, a write-1-to-clear expiry flag and a level interrupt.
module mmio_timer_slave #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 7,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic                  we,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rd,
  output logic                  irq
);

  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_LOAD     = 3'd1,
    REG_COUNT    = 3'd2,
    REG_STATUS   = 3'd3,
    REG_PRESCALE = 3'd4
  } reg_sel_e;

  logic                      en_q;
  logic                      auto_reload_q;
  logic                      irq_en_q;
  logic                      expired_q;
  logic [DATA_WIDTH-1:0]     load_q;
  logic [DATA_WIDTH-1:0]     count_q;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic [PRESCALE_WIDTH-1:0] pcnt_q;

  logic [2:0] sel;
  logic       wr_ctrl;
  logic       wr_load;
  logic       wr_status;
  logic       wr_prescale;
  logic       tick;
  logic       expire;
  logic [ADDR_WIDTH-4:0] unused_addr_bits;

  assign sel              = address[4:2];
  assign unused_addr_bits = {address[ADDR_WIDTH-1:5], address[1:0]};

  assign wr_ctrl     = we && (sel == REG_CTRL);
  assign wr_load     = we && (sel == REG_LOAD);
  assign wr_status   = we && (sel == REG_STATUS);
  assign wr_prescale = we && (sel == REG_PRESCALE);

  assign tick   = en_q && (pcnt_q == prescale_q);
  assign expire = tick && (count_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q          <= 1'b0;
      auto_reload_q <= 1'b0;
      irq_en_q      <= 1'b0;
      expired_q     <= 1'b0;
      load_q        <= '0;
      count_q       <= '0;
      prescale_q    <= '0;
      pcnt_q        <= '0;
    end else begin
      // Clear is placed before the expiry update so a same-edge expiry wins.
      if (wr_status && wd[0]) expired_q <= 1'b0;

      if (tick) begin
        pcnt_q <= '0;
        if (count_q != '0) begin
          count_q <= count_q - DATA_WIDTH'(1);
        end else begin
          expired_q <= 1'b1;
          if (auto_reload_q) count_q <= load_q;
          else               en_q    <= 1'b0;
        end
      end else if (en_q) begin
        pcnt_q <= pcnt_q + PRESCALE_WIDTH'(1);
      end

      // Bus write to CTRL comes last so its en overrides a one-shot auto-disable.
      if (wr_ctrl) begin
        en_q          <= wd[0];
        auto_reload_q <= wd[1];
        irq_en_q      <= wd[2];
        if (wd[0] && !en_q) begin
          count_q <= load_q;
          pcnt_q  <= '0;
        end
      end

      if (wr_load)     load_q     <= wd;
      if (wr_prescale) prescale_q <= wd[PRESCALE_WIDTH-1:0];
    end
  end

  always_comb begin
    rd = '0;
    if (re) begin
      case (sel)
        REG_CTRL:     rd[2:0] = {irq_en_q, auto_reload_q, en_q};
        REG_LOAD:     rd = load_q;
        REG_COUNT:    rd = count_q;
        REG_STATUS:   rd[0] = expired_q;
        REG_PRESCALE: rd[PRESCALE_WIDTH-1:0] = prescale_q;
        default:      rd = '0;
      endcase
    end
  end

  assign irq = expired_q & irq_en_q;

endmodule
